// File: rtl/axi_burst_master.sv
// AXI4 INCR burst master: one outstanding write burst and one outstanding read burst, driven from a simple command/beat user interface.
// Optional 4 KB boundary rejection when AXI_MASTER_4K_CHECK_EN is defined.
module axi_burst_master #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_USER_WIDTH = 10,
  parameter int MASTER_ID      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // AW channel
  output logic [AXI_ID_WIDTH-1:0]   awid,
  output logic [AXI_ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awlock,
  output logic [3:0]                awcache,
  output logic [2:0]                awprot,
  output logic [3:0]                awqos,
  output logic [3:0]                awregion,
  output logic [AXI_USER_WIDTH-1:0] awuser,
  output logic                      awvalid,
  input  logic                      awready,
  // W channel
  output logic [AXI_ID_WIDTH-1:0]   wid,
  output logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic [AXI_STRB_WIDTH-1:0] wstrb,
  output logic                      wlast,
  output logic [AXI_USER_WIDTH-1:0] wuser,
  output logic                      wvalid,
  input  logic                      wready,
  // B channel
  input  logic [AXI_ID_WIDTH-1:0]   bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  // AR channel
  output logic [AXI_ID_WIDTH-1:0]   arid,
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic [3:0]                arqos,
  output logic [3:0]                arregion,
  output logic [AXI_USER_WIDTH-1:0] aruser,
  output logic                      arvalid,
  input  logic                      arready,
  // R channel
  input  logic [AXI_ID_WIDTH-1:0]   rid,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  // user write side
  input  logic                      wr_cmd_valid,
  output logic                      wr_cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_cmd_addr,
  input  logic [7:0]                wr_cmd_len,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data,
  input  logic [AXI_STRB_WIDTH-1:0] wr_strb,
  input  logic                      wr_data_valid,
  output logic                      wr_data_ready,
  output logic                      wr_done,
  output logic [1:0]                wr_resp,
  // user read side
  input  logic                      rd_cmd_valid,
  output logic                      rd_cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] rd_cmd_addr,
  input  logic [7:0]                rd_cmd_len,
  output logic [AXI_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_data_last,
  output logic                      rd_data_valid,
  input  logic                      rd_data_ready,
  output logic                      rd_done,
  output logic [1:0]                rd_resp
);

  localparam logic [2:0] BEAT_SIZE = 3'($clog2(AXI_STRB_WIDTH));

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  wstate_t                   wstate_q, wstate_d;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]                wlen_q, wlen_d;
  logic [7:0]                wcnt_q, wcnt_d;
  logic                      wr_done_q, wr_done_d;
  logic [1:0]                wr_resp_q, wr_resp_d;

  rstate_t                   rstate_q, rstate_d;
  logic [AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]                rlen_q, rlen_d;
  logic [1:0]                rworst_q, rworst_d;
  logic                      rd_done_q, rd_done_d;
  logic [1:0]                rd_resp_q, rd_resp_d;

  logic                      wr_reject, rd_reject;
  logic [1:0]                rworst_now;
  logic                      unused_ids;

  assign unused_ids = ^{bid, rid};

`ifdef AXI_MASTER_4K_CHECK_EN
  // A burst whose last byte lands past the current 4 KB page is refused.
  function automatic logic crosses_4k(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                      input logic [7:0] len);
    logic [31:0] end_byte;
    end_byte = 32'(addr[11:0]) + (32'(len) + 32'd1) * 32'(AXI_STRB_WIDTH);
    return end_byte > 32'd4096;
  endfunction

  assign wr_reject = crosses_4k(wr_cmd_addr, wr_cmd_len);
  assign rd_reject = crosses_4k(rd_cmd_addr, rd_cmd_len);
`else
  assign wr_reject = 1'b0;
  assign rd_reject = 1'b0;
`endif

  always_comb begin
    wstate_d  = wstate_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wr_done_d = 1'b0;
    wr_resp_d = wr_resp_q;
    case (wstate_q)
      W_IDLE: begin
        if (wr_cmd_valid) begin
          waddr_d = wr_cmd_addr;
          wlen_d  = wr_cmd_len;
          wcnt_d  = 8'd0;
          if (wr_reject) begin
            wr_done_d = 1'b1;
            wr_resp_d = 2'b10;
          end else begin
            wstate_d = W_ADDR;
          end
        end
      end
      W_ADDR: if (awready) wstate_d = W_DATA;
      W_DATA: begin
        if (wr_data_valid && wready) begin
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_q == wlen_q) wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid) begin
          wr_resp_d = bresp;
          wr_done_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Worst response so far including the beat currently on the bus.
  assign rworst_now = (rresp > rworst_q) ? rresp : rworst_q;

  always_comb begin
    rstate_d  = rstate_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rworst_d  = rworst_q;
    rd_done_d = 1'b0;
    rd_resp_d = rd_resp_q;
    case (rstate_q)
      R_IDLE: begin
        if (rd_cmd_valid) begin
          raddr_d  = rd_cmd_addr;
          rlen_d   = rd_cmd_len;
          rworst_d = 2'b00;
          if (rd_reject) begin
            rd_done_d = 1'b1;
            rd_resp_d = 2'b10;
          end else begin
            rstate_d = R_ADDR;
          end
        end
      end
      R_ADDR: if (arready) rstate_d = R_DATA;
      R_DATA: begin
        if (rvalid && rd_data_ready) begin
          rworst_d = rworst_now;
          if (rlast) begin
            rd_resp_d = rworst_now;
            rd_done_d = 1'b1;
            rstate_d  = R_IDLE;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wr_done_q <= 1'b0;
      wr_resp_q <= 2'b00;
      rstate_q  <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rworst_q  <= 2'b00;
      rd_done_q <= 1'b0;
      rd_resp_q <= 2'b00;
    end else begin
      wstate_q  <= wstate_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wr_done_q <= wr_done_d;
      wr_resp_q <= wr_resp_d;
      rstate_q  <= rstate_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rworst_q  <= rworst_d;
      rd_done_q <= rd_done_d;
      rd_resp_q <= rd_resp_d;
    end
  end

  assign awid     = AXI_ID_WIDTH'(MASTER_ID);
  assign awaddr   = waddr_q;
  assign awlen    = wlen_q;
  assign awsize   = BEAT_SIZE;
  assign awburst  = 2'b01;
  assign awlock   = 1'b0;
  assign awcache  = 4'd0;
  assign awprot   = 3'd0;
  assign awqos    = 4'd0;
  assign awregion = 4'd0;
  assign awuser   = '0;
  assign awvalid  = (wstate_q == W_ADDR);

  assign wid           = AXI_ID_WIDTH'(MASTER_ID);
  assign wdata         = wr_data;
  assign wstrb         = wr_strb;
  assign wuser         = '0;
  assign wvalid        = (wstate_q == W_DATA) && wr_data_valid;
  assign wlast         = (wstate_q == W_DATA) && (wcnt_q == wlen_q);
  assign wr_data_ready = (wstate_q == W_DATA) && wready;
  assign bready        = (wstate_q == W_RESP);
  assign wr_cmd_ready  = (wstate_q == W_IDLE);
  assign wr_done       = wr_done_q;
  assign wr_resp       = wr_resp_q;

  assign arid     = AXI_ID_WIDTH'(MASTER_ID);
  assign araddr   = raddr_q;
  assign arlen    = rlen_q;
  assign arsize   = BEAT_SIZE;
  assign arburst  = 2'b01;
  assign arlock   = 1'b0;
  assign arcache  = 4'd0;
  assign arprot   = 3'd0;
  assign arqos    = 4'd0;
  assign arregion = 4'd0;
  assign aruser   = '0;
  assign arvalid  = (rstate_q == R_ADDR);

  assign rd_data       = (rstate_q == R_DATA) ? rdata : '0;
  assign rd_data_last  = (rstate_q == R_DATA) && rlast;
  assign rd_data_valid = (rstate_q == R_DATA) && rvalid;
  assign rready        = (rstate_q == R_DATA) && rd_data_ready;
  assign rd_cmd_ready  = (rstate_q == R_IDLE);
  assign rd_done       = rd_done_q;
  assign rd_resp       = rd_resp_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: table of bursts plus hand-written concurrency, 4 KB and reset sequences.
`timescale 1ns/1ps
module tb_axi_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  awid, wid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata, wr_cmd_addr, rd_cmd_addr, wr_data, rd_data;
  logic [7:0]  awlen, arlen, wr_cmd_len, rd_cmd_len;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp, wr_resp, rd_resp;
  logic        awlock, arlock, awvalid, awready, arvalid, arready;
  logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion, wstrb, wr_strb;
  logic [9:0]  awuser, aruser, wuser;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  logic        wr_cmd_valid, wr_cmd_ready, wr_data_valid, wr_data_ready, wr_done;
  logic        rd_cmd_valid, rd_cmd_ready, rd_data_last, rd_data_valid, rd_data_ready, rd_done;

  int n_chk = 0;
  int n_fail = 0;

  axi_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos), .awregion(awregion),
    .awuser(awuser), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos), .arregion(arregion),
    .aruser(aruser), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_len(wr_cmd_len), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .wr_done(wr_done), .wr_resp(wr_resp),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_len(rd_cmd_len), .rd_data(rd_data), .rd_data_last(rd_data_last),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .rd_done(rd_done), .rd_resp(rd_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] base;
    bit          bp;
    int          bad_beat;
    logic [1:0]  bad_resp;
    logic [1:0]  exp_resp;
  } txn_t;

  txn_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cmd(input logic [31:0] addr, input logic [7:0] len, input int delay);
    wr_cmd_valid = 1'b1; wr_cmd_addr = addr; wr_cmd_len = len;
    #1 chk("wr_cmd_ready", wr_cmd_ready, 1);
    tick();
    wr_cmd_valid = 1'b0;
    for (int k = 0; k < delay; k++) begin
      chk("awvalid_hold", awvalid, 1);
      chk("awaddr_hold", awaddr, addr);
      tick();
    end
    awready = 1'b1;
    #1;
    chk("awvalid", awvalid, 1);
    chk("awaddr", awaddr, addr);
    chk("awlen", awlen, len);
    chk("awsize", awsize, 2);
    chk("awburst", awburst, 1);
    chk("awid", awid, 0);
    tick();
    awready = 1'b0;
  endtask

  task automatic wr_data_phase(input logic [7:0] len, input logic [31:0] base);
    for (int i = 0; i <= int'(len); i++) begin
      wr_data_valid = 1'b1; wr_data = base + i; wr_strb = 4'hF; wready = 1'b1;
      #1;
      chk("wvalid", wvalid, 1);
      chk("wdata", wdata, base + i);
      chk("wlast", wlast, (i == int'(len)));
      chk("wr_data_ready", wr_data_ready, 1);
      tick();
    end
    wr_data_valid = 1'b0; wready = 1'b0;
  endtask

  task automatic wr_resp_phase(input logic [1:0] resp);
    bvalid = 1'b1; bresp = resp;
    #1 chk("bready", bready, 1);
    chk("wr_done_early", wr_done, 0);
    tick();
    bvalid = 1'b0;
    chk("wr_done", wr_done, 1);
    chk("wr_resp", wr_resp, resp);
    tick();
    chk("wr_done_clear", wr_done, 0);
    chk("wr_cmd_ready_after", wr_cmd_ready, 1);
  endtask

  task automatic rd_cmd(input logic [31:0] addr, input logic [7:0] len);
    rd_cmd_valid = 1'b1; rd_cmd_addr = addr; rd_cmd_len = len;
    #1 chk("rd_cmd_ready", rd_cmd_ready, 1);
    tick();
    rd_cmd_valid = 1'b0;
    arready = 1'b1;
    #1;
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, addr);
    chk("arlen", arlen, len);
    chk("arsize", arsize, 2);
    chk("arburst", arburst, 1);
    tick();
    arready = 1'b0;
  endtask

  task automatic rd_data_phase(input logic [7:0] len, input logic [31:0] base, input bit bp,
                               input int bad_beat, input logic [1:0] bad_resp,
                               input logic [1:0] exp_resp);
    int  i = 0;
    int  cyc = 0;
    bit  hs;
    while (i <= int'(len) && cyc < 64) begin
      rvalid = 1'b1; rdata = base + i; rresp = (i == bad_beat) ? bad_resp : 2'b00;
      rlast = (i == int'(len)); rd_data_ready = bp ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk("rd_data_valid", rd_data_valid, 1);
      chk("rd_data", rd_data, base + i);
      chk("rd_data_last", rd_data_last, (i == int'(len)));
      chk("rready", rready, rd_data_ready);
      hs = rd_data_ready;
      tick();
      if (hs) i++;
      cyc++;
    end
    if (i <= int'(len)) chk("rd_beats_timeout", i, int'(len) + 1);
    rvalid = 1'b0; rlast = 1'b0; rd_data_ready = 1'b0;
    chk("rd_done", rd_done, 1);
    chk("rd_resp", rd_resp, exp_resp);
    tick();
    chk("rd_done_clear", rd_done, 0);
    chk("rd_cmd_ready_after", rd_cmd_ready, 1);
  endtask

  initial begin
    tbl[0] = '{is_rd: 1'b0, addr: 32'h100, len: 8'd3, base: 32'd1, bp: 1'b0,
               bad_beat: -1, bad_resp: 2'b00, exp_resp: 2'b00};
    tbl[1] = '{is_rd: 1'b1, addr: 32'h40, len: 8'd0, base: 32'hDEADBEEF, bp: 1'b0,
               bad_beat: -1, bad_resp: 2'b00, exp_resp: 2'b00};
    tbl[2] = '{is_rd: 1'b1, addr: 32'h800, len: 8'd7, base: 32'hA000, bp: 1'b1,
               bad_beat: 4, bad_resp: 2'b10, exp_resp: 2'b10};
    tbl[3] = '{is_rd: 1'b0, addr: 32'h200, len: 8'd0, base: 32'h55, bp: 1'b0,
               bad_beat: -1, bad_resp: 2'b11, exp_resp: 2'b11};
    tbl[4] = '{is_rd: 1'b1, addr: 32'h300, len: 8'd2, base: 32'h77, bp: 1'b0,
               bad_beat: 1, bad_resp: 2'b01, exp_resp: 2'b01};

    rst_n = 1'b0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    wr_cmd_valid = 0; wr_cmd_addr = 0; wr_cmd_len = 0; wr_data = 0; wr_strb = 0; wr_data_valid = 0;
    rd_cmd_valid = 0; rd_cmd_addr = 0; rd_cmd_len = 0; rd_data_ready = 0;
    #2;
    chk("rst_wr_cmd_ready", wr_cmd_ready, 1);
    chk("rst_rd_cmd_ready", rd_cmd_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rd_data_valid", rd_data_valid, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_wr_resp", wr_resp, 0);
    chk("rst_rd_resp", rd_resp, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_araddr", araddr, 0);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    for (int t = 0; t < 5; t++) begin
      if (tbl[t].is_rd) begin
        rd_cmd(tbl[t].addr, tbl[t].len);
        rd_data_phase(tbl[t].len, tbl[t].base, tbl[t].bp, tbl[t].bad_beat,
                      tbl[t].bad_resp, tbl[t].exp_resp);
      end else begin
        wr_cmd(tbl[t].addr, tbl[t].len, 0);
        wr_data_phase(tbl[t].len, tbl[t].base);
        wr_resp_phase(tbl[t].exp_resp);
      end
    end

    // Simultaneous write and read commands with slow address ready.
    wr_cmd_valid = 1; wr_cmd_addr = 32'h500; wr_cmd_len = 8'd1;
    rd_cmd_valid = 1; rd_cmd_addr = 32'h600; rd_cmd_len = 8'd1;
    #1;
    chk("sim_wr_cmd_ready", wr_cmd_ready, 1);
    chk("sim_rd_cmd_ready", rd_cmd_ready, 1);
    tick();
    wr_cmd_valid = 0; rd_cmd_valid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("sim_awvalid_hold", awvalid, 1);
      chk("sim_arvalid_hold", arvalid, 1);
      chk("sim_awaddr_hold", awaddr, 32'h500);
      chk("sim_araddr_hold", araddr, 32'h600);
      tick();
    end
    awready = 1; arready = 1;
    #1;
    chk("sim_awvalid", awvalid, 1);
    chk("sim_arvalid", arvalid, 1);
    tick();
    awready = 0; arready = 0;
    chk("sim_awvalid_drop", awvalid, 0);
    chk("sim_arvalid_drop", arvalid, 0);
    wr_data_phase(8'd1, 32'h1000);
    wr_resp_phase(2'b00);
    rd_data_phase(8'd1, 32'h2000, 1'b0, -1, 2'b00, 2'b00);

    // Write that crosses a 4 KB page.
`ifdef AXI_MASTER_4K_CHECK_EN
    wr_cmd_valid = 1; wr_cmd_addr = 32'hFF8; wr_cmd_len = 8'd3;
    #1 chk("4k_wr_cmd_ready", wr_cmd_ready, 1);
    tick();
    wr_cmd_valid = 0;
    chk("4k_awvalid", awvalid, 0);
    chk("4k_wr_data_ready", wr_data_ready, 0);
    chk("4k_wr_done", wr_done, 1);
    chk("4k_wr_resp", wr_resp, 2'b10);
    tick();
    chk("4k_wr_done_clear", wr_done, 0);
    chk("4k_awvalid_idle", awvalid, 0);
`else
    wr_cmd(32'hFF8, 8'd3, 0);
    wr_data_phase(8'd3, 32'h3000);
    wr_resp_phase(2'b00);
`endif

    // Reset during beat 2 of a len 3 write.
    wr_cmd(32'h700, 8'd3, 0);
    wr_data_valid = 1; wr_data = 32'h11; wr_strb = 4'hF; wready = 1;
    tick();
    wr_data = 32'h12;
    #1 chk("rst_mid_wvalid_before", wvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wvalid", wvalid, 0);
    chk("rst_mid_awvalid", awvalid, 0);
    chk("rst_mid_bready", bready, 0);
    chk("rst_mid_wr_data_ready", wr_data_ready, 0);
    wr_data_valid = 0; wready = 0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_mid_wr_cmd_ready", wr_cmd_ready, 1);
    chk("rst_mid_wr_done", wr_done, 0);
    chk("rst_mid_rd_cmd_ready", rd_cmd_ready, 1);

    // The path works again after the abandoned burst.
    wr_cmd(32'h900, 8'd0, 1);
    wr_data_phase(8'd0, 32'h99);
    wr_resp_phase(2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
